// File: rtl/usb3_ep_in_pktbuf_pkg.sv
// ============================================================================
// Module   : usb3_ep_in_pktbuf_pkg
// Purpose  : Shared defaults and width helpers for the IN-endpoint packet
//            buffer and its RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb3_ep_in_pktbuf_pkg;

  localparam int DATA_W_DEF          = 32;
  localparam int DEPTH_DEF           = 256;
  localparam int NUM_BUF_DEF         = 2;
  localparam int LEN_W_DEF           = 11;
  localparam int USB3_MAX_PKT_BYTES  = 1024;
  localparam int RETRY_W             = 8;

  // Word-address width inside one packet slot.
  function automatic int adr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Slot-index width; a single slot still needs one (constant-zero) bit.
  function automatic int slot_w(input int num_buf);
    return (num_buf > 1) ? $clog2(num_buf) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb3_ep_in_pktbuf_ram.sv
// ============================================================================
// Module   : usb3_ep_in_pktbuf_ram
// Purpose  : Simple dual-port RAM, synchronous write, registered read with
//            read-before-write behaviour on an address collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb3_ep_in_pktbuf_ram #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [DATA_W-1:0] wdat,
  input  logic [ADDR_W-1:0] radr,
  output logic [DATA_W-1:0] rdat
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdat_d;
  logic [DATA_W-1:0] rdat_q;

  // Read the old contents; a write in the same cycle lands after this sample.
  always_comb begin
    rdat_d = mem_q[radr];
  end

  // Storage array: plain synchronous write, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wadr] <= wdat;
    end
  end

  // Output register gives the fixed one-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdat_q <= '0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign rdat = rdat_q;

endmodule

`default_nettype wire

// File: rtl/usb3_ep_in_pktbuf.sv
// ============================================================================
// Module   : usb3_ep_in_pktbuf
// Purpose  : Multi-slot IN-endpoint packet buffer. The application streams
//            words in and commits packets; the TX side reads the head packet
//            by word address and releases (ACK) or re-reads (retry) it.
// Options  : USB3_EP_IN_PKTBUF_FLUSH_EN adds a synchronous flush input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb3_ep_in_pktbuf
  import usb3_ep_in_pktbuf_pkg::*;
#(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  parameter  int NUM_BUF = NUM_BUF_DEF,
  parameter  int LEN_W   = LEN_W_DEF,
  localparam int ADR_W   = adr_w(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
`ifdef USB3_EP_IN_PKTBUF_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               wr_we,
  input  logic [DATA_W-1:0]  wr_dat_w,
  input  logic               wr_commit,
  input  logic [LEN_W-1:0]   wr_len,
  output logic               wr_full,
  output logic               wr_ovf,
  output logic               rd_avail,
  output logic [LEN_W-1:0]   rd_len,
  input  logic [ADR_W-1:0]   rd_adr,
  output logic [DATA_W-1:0]  rd_dat_r,
  input  logic               rd_done,
  input  logic               rd_retry,
  output logic [RETRY_W-1:0] rd_retry_cnt
);

  localparam int SLOT_W = slot_w(NUM_BUF);
  localparam int CNT_W  = $clog2(NUM_BUF + 1);
  localparam int PTR_W  = ADR_W + 1;

  logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [SLOT_W-1:0]               wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]               rd_slot_q, rd_slot_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic [NUM_BUF-1:0][LEN_W-1:0]   len_q, len_d;
  logic                            wr_ovf_q, wr_ovf_d;
  logic [RETRY_W-1:0]              retry_cnt_q, retry_cnt_d;

  logic w_flush;
  logic w_we;
  logic w_commit;
  logic w_done;

`ifdef USB3_EP_IN_PKTBUF_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Status outputs are pure functions of registered state.
  always_comb begin
    wr_full      = (count_q == CNT_W'(NUM_BUF));
    rd_avail     = (count_q != '0);
    rd_len       = len_q[rd_slot_q];
    wr_ovf       = wr_ovf_q;
    rd_retry_cnt = retry_cnt_q;
  end

  // Qualified strobes; flush pre-empts every write/commit/release action.
  always_comb begin
    w_we     = wr_we && !wr_full && !wr_ptr_q[ADR_W] && !w_flush;
    w_commit = wr_commit && !wr_full && !w_flush;
    w_done   = rd_done && rd_avail && !w_flush;
  end

  // Next-state for pointers, occupancy, lengths and sticky/diagnostic flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_slot_d   = wr_slot_q;
    rd_slot_d   = rd_slot_q;
    count_d     = count_q;
    len_d       = len_q;
    wr_ovf_d    = wr_ovf_q;
    retry_cnt_d = retry_cnt_q;

    // Writing beyond the slot end drops the word and latches the error.
    if (wr_we && !wr_full && wr_ptr_q[ADR_W] && !w_flush) begin
      wr_ovf_d = 1'b1;
    end
    if (w_we) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    // Commit after any same-cycle write so the last word belongs to the packet.
    if (w_commit) begin
      len_d[wr_slot_q] = wr_len;
      wr_slot_d        = (NUM_BUF == 1) ? '0 : wr_slot_q + SLOT_W'(1);
      wr_ptr_d         = '0;
    end
    if (w_done) begin
      rd_slot_d = (NUM_BUF == 1) ? '0 : rd_slot_q + SLOT_W'(1);
    end

    if (w_commit && !w_done) begin
      count_d = count_q + CNT_W'(1);
    end else if (w_done && !w_commit) begin
      count_d = count_q - CNT_W'(1);
    end

    // A retry only rewinds the reader; it is counted for link diagnostics.
    if (rd_retry && !rd_done && rd_avail) begin
      retry_cnt_d = retry_cnt_q + RETRY_W'(1);
    end

    if (w_flush) begin
      wr_ptr_d  = '0;
      wr_slot_d = '0;
      rd_slot_d = '0;
      count_d   = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      count_q     <= '0;
      len_q       <= '0;
      wr_ovf_q    <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      count_q     <= count_d;
      len_q       <= len_d;
      wr_ovf_q    <= wr_ovf_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  usb3_ep_in_pktbuf_ram #(
    .DATA_W (DATA_W),
    .WORDS  (NUM_BUF * DEPTH),
    .ADDR_W (SLOT_W + ADR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .wadr  ({wr_slot_q, wr_ptr_q[ADR_W-1:0]}),
    .wdat  (wr_dat_w),
    .radr  ({rd_slot_q, rd_adr}),
    .rdat  (rd_dat_r)
  );

  // Committing into a full ring silently loses a packet; flag it in simulation.
  a_no_commit_when_full : assert property (
    @(posedge clk) disable iff (reset) !(wr_commit && wr_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_usb3_ep_in_pktbuf.sv
// ============================================================================
// Module   : tb_usb3_ep_in_pktbuf
// Purpose  : Directed, scoreboard-checked bench for usb3_ep_in_pktbuf.
// Options  : USB3_EP_IN_PKTBUF_FLUSH_EN enables the flush scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb3_ep_in_pktbuf;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int NUM_BUF = 2;
  localparam int LEN_W   = 11;
  localparam int ADR_W   = 4;

  localparam int K_AVAIL = 0;
  localparam int K_FULL  = 1;
  localparam int K_OVF   = 2;
  localparam int K_LEN   = 3;
  localparam int K_DAT   = 4;
  localparam int K_RETRY = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              wr_we = 1'b0;
  logic [DATA_W-1:0] wr_dat_w = '0;
  logic              wr_commit = 1'b0;
  logic [LEN_W-1:0]  wr_len = '0;
  logic              wr_full;
  logic              wr_ovf;
  logic              rd_avail;
  logic [LEN_W-1:0]  rd_len;
  logic [ADR_W-1:0]  rd_adr = '0;
  logic [DATA_W-1:0] rd_dat_r;
  logic              rd_done = 1'b0;
  logic              rd_retry = 1'b0;
  logic [7:0]        rd_retry_cnt;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
    int          due;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  usb3_ep_in_pktbuf #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NUM_BUF (NUM_BUF),
    .LEN_W   (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef USB3_EP_IN_PKTBUF_FLUSH_EN
    .flush        (flush),
`endif
    .wr_we        (wr_we),
    .wr_dat_w     (wr_dat_w),
    .wr_commit    (wr_commit),
    .wr_len       (wr_len),
    .wr_full      (wr_full),
    .wr_ovf       (wr_ovf),
    .rd_avail     (rd_avail),
    .rd_len       (rd_len),
    .rd_adr       (rd_adr),
    .rd_dat_r     (rd_dat_r),
    .rd_done      (rd_done),
    .rd_retry     (rd_retry),
    .rd_retry_cnt (rd_retry_cnt)
  );

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_AVAIL: return {31'b0, rd_avail};
      K_FULL:  return {31'b0, wr_full};
      K_OVF:   return {31'b0, wr_ovf};
      K_LEN:   return {21'b0, rd_len};
      K_DAT:   return rd_dat_r;
      default: return {24'b0, rd_retry_cnt};
    endcase
  endfunction

  // Monitor: on each falling edge, retire every expectation due this cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].due <= cyc) begin
        act = sample(sbq[i].kind);
        n_checks = n_checks + 1;
        if (sbq[i].due < cyc || act !== sbq[i].exp) begin
          n_errors = n_errors + 1;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                   sbq[i].name, act, sbq[i].exp, cyc);
        end
        sbq.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  task automatic expect_val(input int kind, input string name, input logic [31:0] exp);
    chk_t c;
    c.kind = kind;
    c.name = name;
    c.exp  = exp;
    c.due  = cyc;
    sbq.push_back(c);
  endtask

  // One clock of stimulus; strobes drop again just after the edge.
  task automatic drive(input logic we, input logic [31:0] dat, input logic commit,
                       input logic [10:0] len, input logic done, input logic retry,
                       input logic fl);
    wr_we     = we;
    wr_dat_w  = dat;
    wr_commit = commit;
    wr_len    = len;
    rd_done   = done;
    rd_retry  = retry;
    flush     = fl;
    @(posedge clk);
    #1;
    wr_we     = 1'b0;
    wr_commit = 1'b0;
    rd_done   = 1'b0;
    rd_retry  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);    drive(1'b1, d, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic commit(input logic [10:0] l); drive(1'b0, '0, 1'b1, l, 1'b0, 1'b0, 1'b0);   endtask
  task automatic done();                      drive(1'b0, '0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic retry();                     drive(1'b0, '0, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0); endtask

  task automatic rd(input logic [ADR_W-1:0] a);
    rd_adr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    n_checks = n_checks + 1;
    if (rd_avail !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL rst_direct_avail: got %b expected 0", rd_avail);
    end
    n_checks = n_checks + 1;
    if (wr_full !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL rst_direct_full: got %b expected 0", wr_full);
    end
    n_checks = n_checks + 1;
    if (wr_ovf !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL rst_direct_ovf: got %b expected 0", wr_ovf);
    end
    n_checks = n_checks + 1;
    if (rd_dat_r !== 32'h0) begin
      n_errors = n_errors + 1;
      $display("FAIL rst_direct_dat: got 0x%0h expected 0x0", rd_dat_r);
    end

    // Reset state
    expect_val(K_AVAIL, "rst_avail", 0);
    expect_val(K_FULL,  "rst_full",  0);
    expect_val(K_OVF,   "rst_ovf",   0);
    expect_val(K_DAT,   "rst_dat",   0);
    expect_val(K_LEN,   "rst_len",   0);
    expect_val(K_RETRY, "rst_retry", 0);
    rd(0);

    // Basic packet: 4 words, 13 bytes, slot 0
    for (int i = 0; i < 4; i++) wr(32'hA0 + i);
    commit(11'd13);
    expect_val(K_AVAIL, "pk1_avail", 1);
    expect_val(K_LEN,   "pk1_len",   13);
    rd(2);
    expect_val(K_DAT,   "pk1_dat2",  32'hA2);
    done();
    expect_val(K_AVAIL, "pk1_done_avail", 0);
    done();
    expect_val(K_AVAIL, "done_empty_ignored", 0);

    // Fill both slots (slot1 then slot0), write while full must be ignored
    wr(32'hB0); wr(32'hB1); commit(11'd8);
    wr(32'hC0); wr(32'hC1); commit(11'd8);
    expect_val(K_FULL, "full_after_two", 1);
    wr(32'hD0);
    rd(0);
    expect_val(K_DAT,  "head_b0_intact", 32'hB0);
    expect_val(K_LEN,  "len_b", 8);
    done();
    expect_val(K_FULL,  "full_cleared", 0);
    expect_val(K_AVAIL, "c_avail", 1);
    expect_val(K_LEN,   "len_c", 8);
    wr(32'hE0); wr(32'hE1); wr(32'hE2); commit(11'd12);
    expect_val(K_FULL, "full_again", 1);
    rd(1);
    expect_val(K_DAT, "c_dat1", 32'hC1);
    done();
    expect_val(K_LEN, "len_e", 12);
    rd(2);
    expect_val(K_DAT, "e_dat2", 32'hE2);
    done();
    expect_val(K_AVAIL, "ring_empty", 0);

    // Overflow: DEPTH+1 writes into slot 0
    for (int i = 0; i <= DEPTH; i++) wr(32'h100 + i);
    expect_val(K_OVF, "ovf_set", 1);
    commit(11'd64);
    rd(4'(DEPTH - 1));
    expect_val(K_DAT, "ovf_last_word", 32'h10F);
    rd(0);
    expect_val(K_DAT, "ovf_word0", 32'h100);
    expect_val(K_LEN, "ovf_len", 64);
    wr(32'h200); commit(11'd4);
    done();
    expect_val(K_LEN, "next_len", 4);
    rd(0);
    expect_val(K_DAT, "next_dat0", 32'h200);
    done();
    expect_val(K_AVAIL, "ovf_empty", 0);

    // Zero-length packet with retries
    commit(11'd0);
    expect_val(K_AVAIL, "zlp_avail", 1);
    expect_val(K_LEN,   "zlp_len", 0);
    retry(); retry(); retry();
    expect_val(K_AVAIL, "zlp_retry_avail", 1);
    expect_val(K_RETRY, "retry_cnt", 3);
    expect_val(K_LEN,   "zlp_retry_len", 0);
    done();
    expect_val(K_AVAIL, "zlp_done", 0);

    // Commit + done together, with a same-cycle final write
    wr(32'h300); commit(11'd20);
    wr(32'h400);
    drive(1'b1, 32'h401, 1'b1, 11'd24, 1'b1, 1'b0, 1'b0);
    expect_val(K_AVAIL, "cd_avail", 1);
    expect_val(K_LEN,   "cd_len", 24);
    expect_val(K_FULL,  "cd_full", 0);
    rd(1);
    expect_val(K_DAT, "cd_dat1", 32'h401);
    rd(0);
    expect_val(K_DAT, "cd_dat0", 32'h400);
    done();
    expect_val(K_AVAIL, "cd_empty", 0);
    expect_val(K_OVF,   "ovf_sticky", 1);

`ifdef USB3_EP_IN_PKTBUF_FLUSH_EN
    commit(11'd0); commit(11'd0);
    expect_val(K_FULL, "pre_flush_full", 1);
    drive(1'b0, '0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
    expect_val(K_AVAIL, "flush_avail", 0);
    expect_val(K_FULL,  "flush_full", 0);
    expect_val(K_OVF,   "flush_ovf_kept", 1);
`endif

    repeat (2) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (rd_avail !== 1'b0) begin
      n_errors = n_errors + 1;
      $display("FAIL end_direct_avail: got %b expected 0", rd_avail);
    end
    while (sbq.size() > 0) begin
      n_checks = n_checks + 1;
      n_errors = n_errors + 1;
      $display("FAIL %s: never checked, expected 0x%0h", sbq[0].name, sbq[0].exp);
      void'(sbq.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
